// File: rtl/poss_seq.sv
// poss_seq: power-on self-set sequencer for CMD-3 modules.
// Walks a synchronous address/data configuration table and issues one
// register write per entry over a req/ack port. Reports busy/done/error.
// Optional feature macro: POSS_SEQ_TIMEOUT_EN (per-write ack timeout and ERR state).
module poss_seq #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int N_ENTRIES = 16,
    parameter int TIMEOUT   = 255,
    localparam int IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic              tbl_last,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    // The ack wait limit must allow at least one WRITE cycle.
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("poss_seq: TIMEOUT must be >= 1");
    end

    state_t state;
    logic   start_d;
    logic   last_q;
    logic   start_edge;

    assign start_edge = start & ~start_d;

`ifdef POSS_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             error_q;

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Sequencer FSM with registered outputs; start edge detector included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            start_d <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tbl_idx <= '0;
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            last_q  <= 1'b0;
`ifdef POSS_SEQ_TIMEOUT_EN
            to_cnt  <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            start_d <= start;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state   <= S_FETCH;
                        tbl_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // tbl_idx is presented; table output is valid next cycle.
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    wr_addr <= tbl_addr;
                    wr_data <= tbl_data;
                    last_q  <= tbl_last | (tbl_idx == LAST_IDX);
                    wr_req  <= 1'b1;
`ifdef POSS_SEQ_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        if (last_q) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            tbl_idx <= tbl_idx + 1'b1;
                            state   <= S_FETCH;
                        end
                    end
`ifdef POSS_SEQ_TIMEOUT_EN
                    // An ack on the limit edge takes priority over the timeout.
                    else if (to_cnt == CNT_LIMIT) begin
                        wr_req  <= 1'b0;
                        busy    <= 1'b0;
                        error_q <= 1'b1;
                        state   <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    // Terminal until reset.
                end
`ifdef POSS_SEQ_TIMEOUT_EN
                S_ERR: begin
                    if (start_edge) begin
                        state   <= S_FETCH;
                        tbl_idx <= '0;
                        error_q <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poss_seq.sv
// Self-checking bench for poss_seq: randomized tables and ack delays,
// scoreboard of expected writes filled by a table-walk reference model.
module tb_poss_seq;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int N      = 16;
    localparam int TO     = 8;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy, done, error;
    logic [IDX_W-1:0]  tbl_idx;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic              tbl_last;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic [ADDR_W-1:0] t_addr [N];
    logic [DATA_W-1:0] t_data [N];
    logic              t_last [N];
    int                ack_delay [N];
    bit                junk_ack;

    int tests = 0;
    int fails = 0;
    logic [27:0] exp_q [$];
    int busy_cycles, wr_count, req_cycles1;
    int wcnt = 0;

    poss_seq #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .N_ENTRIES(N),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .error(error),
        .tbl_idx(tbl_idx),
        .tbl_addr(tbl_addr),
        .tbl_data(tbl_data),
        .tbl_last(tbl_last),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    // Synchronous table ROM: one cycle read latency.
    always @(posedge clk) begin
        tbl_addr <= t_addr[tbl_idx];
        tbl_data <= t_data[tbl_idx];
        tbl_last <= t_last[tbl_idx];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-port responder: ack after ack_delay[idx] cycles of wr_req; optional junk ack when idle.
    always @(negedge clk) begin
        if (wr_req) begin
            wr_ack = (wcnt == ack_delay[tbl_idx]);
            wcnt++;
        end else begin
            wcnt = 0;
            wr_ack = junk_ack ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: an accepted write is wr_req & wr_ack seen before the next rising edge.
    always @(negedge clk) begin
        #2;
        if (busy) busy_cycles++;
        if (rst_n && wr_req && tbl_idx == 4'd1) req_cycles1++;
        if (rst_n && wr_req && wr_ack) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got idx=%0d addr=0x%0h data=0x%0h, expected none",
                         tbl_idx, wr_addr, wr_data);
            end else begin
                check("write", {4'b0, tbl_idx, wr_addr, wr_data}, {4'b0, exp_q.pop_front()});
            end
        end
    end

    // Reference model: walk the table from 0, stop at tbl_last or the final entry,
    // or at the first entry whose ack comes too late when the timeout is built in.
    task automatic model_run(output bit err, output int idx);
        err = 1'b0;
        idx = 0;
        for (int i = 0; i < N; i++) begin
            idx = i;
`ifdef POSS_SEQ_TIMEOUT_EN
            if (ack_delay[i] >= TO) begin
                err = 1'b1;
                break;
            end
`endif
            exp_q.push_back({4'(i), t_addr[i], t_data[i]});
            if (t_last[i]) break;
        end
    endtask

    task automatic load_table(input int last_pos);
        for (int i = 0; i < N; i++) begin
            t_addr[i] = 8'($urandom);
            t_data[i] = 16'($urandom);
            t_last[i] = (i == last_pos);
        end
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < N; i++) ack_delay[i] = d;
    endtask

    task automatic do_reset(input logic start_lvl);
        @(negedge clk);
        rst_n = 1'b0;
        start = start_lvl;
        repeat (2) @(negedge clk);
        exp_q.delete();
        busy_cycles = 0;
        wr_count    = 0;
        req_cycles1 = 0;
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_check(input string name, input bit exp_err, input int exp_idx);
        int n;
        n = 0;
        while (!(done || error) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        check({name, "_flags"}, {28'b0, done, error, busy, wr_req}, {28'b0, ~exp_err, exp_err, 2'b00});
        check({name, "_idx"}, 32'(tbl_idx), 32'(exp_idx));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit m_err;
        int m_idx;
        int n;
        int lp;

        rst_n    = 1'b0;
        start    = 1'b0;
        wr_ack   = 1'b0;
        junk_ack = 1'b0;
        busy_cycles = 0;
        wr_count    = 0;
        req_cycles1 = 0;
        load_table(-1);
        set_delays(0);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {1'b0, busy, done, error, wr_req, tbl_idx, wr_addr, wr_data},
              32'd0);

        // Directed 3-entry table, ack one cycle after req
        do_reset(1'b0);
        load_table(-1);
        t_addr[0] = 8'h10; t_data[0] = 16'h1234;
        t_addr[1] = 8'h11; t_data[1] = 16'hABCD;
        t_addr[2] = 8'h12; t_data[2] = 16'h0001; t_last[2] = 1'b1;
        set_delays(1);
        model_run(m_err, m_idx);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        check("start_busy_idx", {30'b0, busy, wr_req}, 32'd2);
        check("start_idx0", 32'(tbl_idx), 32'd0);
        @(posedge clk); #1;
        check("req_low_n1", 32'(wr_req), 32'd0);
        @(posedge clk); #1;
        check("req_high_n2", 32'(wr_req), 32'd1);
        @(negedge clk);
        start = 1'b0;
        finish_check("three", m_err, m_idx);
        check("three_busy_cycles", 32'(busy_cycles), 32'd12);
        check("three_writes", 32'(wr_count), 32'd3);

        // Start edge after done is ignored
        pulse_start();
        repeat (20) @(negedge clk);
        check("done_restart_writes", 32'(wr_count), 32'd3);
        check("done_restart_state", {27'b0, done, busy, tbl_idx[2:0]}, {27'b0, 1'b1, 1'b0, 3'd2});

        // 16 entries without tbl_last, immediate ack
        do_reset(1'b0);
        load_table(-1);
        set_delays(0);
        model_run(m_err, m_idx);
        pulse_start();
        finish_check("full16", m_err, m_idx);
        check("full16_writes", 32'(wr_count), 32'd16);
        check("full16_busy_cycles", 32'(busy_cycles), 32'd48);

        // Start held high through reset (one run), toggled mid-run (ignored)
        load_table(5);
        for (int i = 0; i < N; i++) ack_delay[i] = $urandom_range(0, 2);
        do_reset(1'b1);
        model_run(m_err, m_idx);
        repeat (8) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_check("held_start", m_err, m_idx);
        check("held_start_writes", 32'(wr_count), 32'd6);

`ifdef POSS_SEQ_TIMEOUT_EN
        // Entry 1 never acked: timeout after TO WRITE cycles, then retry from 0
        do_reset(1'b0);
        load_table(3);
        set_delays(0);
        ack_delay[1] = 1000;
        model_run(m_err, m_idx);
        pulse_start();
        finish_check("timeout", m_err, m_idx);
        check("timeout_req_cycles", 32'(req_cycles1), 32'(TO));
        set_delays(0);
        model_run(m_err, m_idx);
        pulse_start();
        finish_check("retry", m_err, m_idx);
        check("retry_writes", 32'(wr_count), 32'd5);

        // Ack on the exact timeout edge wins
        do_reset(1'b0);
        load_table(3);
        set_delays(0);
        ack_delay[1] = TO - 1;
        model_run(m_err, m_idx);
        pulse_start();
        finish_check("edge_ack", m_err, m_idx);
        check("edge_ack_err", 32'(m_err), 32'd0);
`else
        // No timeout: a long ack wait still completes without error
        do_reset(1'b0);
        load_table(3);
        set_delays(0);
        ack_delay[1] = 3 * TO;
        model_run(m_err, m_idx);
        pulse_start();
        finish_check("long_ack", m_err, m_idx);
        check("long_ack_writes", 32'(wr_count), 32'd4);
`endif

        // Reset asserted during the WRITE of entry 2, then restart
        do_reset(1'b0);
        load_table(5);
        set_delays(0);
        ack_delay[2] = 50;
        exp_q.push_back({4'd0, t_addr[0], t_data[0]});
        exp_q.push_back({4'd1, t_addr[1], t_data[1]});
        pulse_start();
        n = 0;
        while (!(wr_req && tbl_idx == 4'd2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_entry2", 32'(n < 500), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {1'b0, busy, done, error, wr_req, tbl_idx, wr_addr, wr_data},
              32'd0);
        check("rst_mid_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        set_delays(0);
        busy_cycles = 0;
        wr_count    = 0;
        rst_n = 1'b1;
        model_run(m_err, m_idx);
        pulse_start();
        finish_check("rst_restart", m_err, m_idx);
        check("rst_restart_writes", 32'(wr_count), 32'd6);

        // Randomized tables, ack delays and idle junk acks
        junk_ack = 1'b1;
        for (int r = 0; r < 8; r++) begin
            do_reset(1'b0);
            lp = $urandom_range(0, N);
            load_table(lp == N ? -1 : lp);
            for (int i = 0; i < N; i++) begin
`ifdef POSS_SEQ_TIMEOUT_EN
                ack_delay[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1)
                                                          : $urandom_range(0, 3);
`else
                ack_delay[i] = $urandom_range(0, 12);
`endif
            end
            model_run(m_err, m_idx);
            pulse_start();
            finish_check($sformatf("rand%0d", r), m_err, m_idx);
        end
        junk_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
